// File: rtl/vkbd_pkg.sv
// vkbd_pkg: PS/2 set-2 to Vector-06C key matrix types, byte constants and scancode table
package vkbd_pkg;
  typedef enum logic [1:0] {K_MATRIX, K_SS, K_US, K_CAPS} key_kind_e;
  typedef struct packed {
    logic      hit;
    key_kind_e kind;
    logic [2:0] row;
    logic [2:0] col;
  } vkey_t;
  localparam logic [7:0] B_BRK    = 8'hF0;
  localparam logic [7:0] B_EXT    = 8'hE0;
  localparam logic [7:0] B_PAUSE  = 8'hE1;
  localparam logic [7:0] B_ACK    = 8'hFA;
  localparam logic [7:0] B_BAT    = 8'hAA;
  localparam logic [7:0] B_ECHO   = 8'hEE;
  localparam logic [7:0] B_RESEND = 8'hFE;
  localparam logic [7:0] B_ERR0   = 8'h00;
  localparam logic [7:0] B_ERR1   = 8'hFF;
  function automatic logic is_ignored(input logic [7:0] c);
    return c inside {B_ACK, B_BAT, B_ECHO, B_RESEND, B_PAUSE};
  endfunction
  function automatic logic is_error(input logic [7:0] c);
    return c == B_ERR0 || c == B_ERR1;
  endfunction
  // matrix positions are written as octal row/col pairs: 6'o41 = row 4, col 1
  function automatic vkey_t mx(input logic [5:0] rc);
    return '{1'b1, K_MATRIX, rc[5:3], rc[2:0]};
  endfunction
  function automatic vkey_t md(input key_kind_e k);
    return '{1'b1, k, 3'd0, 3'd0};
  endfunction
  function automatic vkey_t vkbd_lookup(input logic ext, input logic [7:0] code);
    vkbd_lookup = '0;
    if (ext)
      case (code)
        8'h6C: vkbd_lookup = mx(6'o00);
        8'h6B: vkbd_lookup = mx(6'o04);
        8'h75: vkbd_lookup = mx(6'o05);
        8'h74: vkbd_lookup = mx(6'o06);
        8'h72: vkbd_lookup = mx(6'o07);
        8'h14: vkbd_lookup = md(K_US);
        default: ;
      endcase
    else
      case (code)
        8'h76: vkbd_lookup = mx(6'o10);
        8'h05: vkbd_lookup = mx(6'o13);
        8'h06: vkbd_lookup = mx(6'o14);
        8'h04: vkbd_lookup = mx(6'o15);
        8'h0C: vkbd_lookup = mx(6'o16);
        8'h03: vkbd_lookup = mx(6'o17);
        8'h0D: vkbd_lookup = mx(6'o20);
        8'h5A: vkbd_lookup = mx(6'o22);
        8'h66: vkbd_lookup = mx(6'o23);
        8'h29: vkbd_lookup = mx(6'o27);
        8'h45: vkbd_lookup = mx(6'o40);
        8'h16: vkbd_lookup = mx(6'o41);
        8'h1E: vkbd_lookup = mx(6'o42);
        8'h26: vkbd_lookup = mx(6'o43);
        8'h25: vkbd_lookup = mx(6'o44);
        8'h2E: vkbd_lookup = mx(6'o45);
        8'h36: vkbd_lookup = mx(6'o46);
        8'h3D: vkbd_lookup = mx(6'o47);
        8'h3E: vkbd_lookup = mx(6'o50);
        8'h46: vkbd_lookup = mx(6'o51);
        8'h52: vkbd_lookup = mx(6'o52);
        8'h4C: vkbd_lookup = mx(6'o53);
        8'h41: vkbd_lookup = mx(6'o54);
        8'h4E: vkbd_lookup = mx(6'o55);
        8'h49: vkbd_lookup = mx(6'o56);
        8'h4A: vkbd_lookup = mx(6'o57);
        8'h54: vkbd_lookup = mx(6'o60);
        8'h1C: vkbd_lookup = mx(6'o61);
        8'h32: vkbd_lookup = mx(6'o62);
        8'h21: vkbd_lookup = mx(6'o63);
        8'h23: vkbd_lookup = mx(6'o64);
        8'h24: vkbd_lookup = mx(6'o65);
        8'h2B: vkbd_lookup = mx(6'o66);
        8'h34: vkbd_lookup = mx(6'o67);
        8'h33: vkbd_lookup = mx(6'o70);
        8'h43: vkbd_lookup = mx(6'o71);
        8'h3B: vkbd_lookup = mx(6'o72);
        8'h42: vkbd_lookup = mx(6'o73);
        8'h4B: vkbd_lookup = mx(6'o74);
        8'h3A: vkbd_lookup = mx(6'o75);
        8'h31: vkbd_lookup = mx(6'o76);
        8'h44: vkbd_lookup = mx(6'o77);
        8'h12: vkbd_lookup = md(K_SS);
        8'h59: vkbd_lookup = md(K_SS);
        8'h14: vkbd_lookup = md(K_US);
        8'h58: vkbd_lookup = md(K_CAPS);
        default: ;
      endcase
  endfunction
endpackage

// File: rtl/vkbd_matrix_ps2_to_vkey.sv
// ps2_to_vkey: combinational scancode-to-matrix-position lookup
module ps2_to_vkey
  import vkbd_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output vkey_t      vkey
);
  assign vkey = vkbd_lookup(ext, code);
endmodule

// File: rtl/vkbd_matrix.sv
// vkbd_matrix: PS/2 scancode stream to live Vector-06C key matrix and modifier lines
module vkbd_matrix
  import vkbd_pkg::*;
#(
  parameter logic [19:0] PREFIX_TIMEOUT = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code,
  input  logic [7:0] row_sel,
  output logic [7:0] cols_n,
  output logic [2:0] mod_n,
  output logic       key_caps,
  output logic       any_key
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;
  state_e      state;
  logic [19:0] cnt;
  logic [7:0]  matrix [8];
  logic        ss, us, caps_held;
  logic        ext, brk, tmo;
  logic [7:0]  sel_or, all_or;
  vkey_t       vk;
  assign ext = state == EXT || state == EXT_BRK;
  assign brk = state == BRK || state == EXT_BRK;
  assign tmo = cnt == PREFIX_TIMEOUT - 20'd1;
  ps2_to_vkey u_lut (.ext, .code, .vkey(vk));
  always_comb begin
    sel_or = '0;
    all_or = '0;
    for (int i = 0; i < 8; i++) begin
      sel_or |= row_sel[i] ? matrix[i] : 8'h00;
      all_or |= matrix[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ss        <= 1'b0;
      us        <= 1'b0;
      caps_held <= 1'b0;
      key_caps  <= 1'b0;
      for (int i = 0; i < 8; i++) matrix[i] <= '0;
    end else if (code_valid) begin
      cnt <= '0;
      if (is_error(code)) begin
        state <= IDLE;
        ss    <= 1'b0;
        us    <= 1'b0;
        for (int i = 0; i < 8; i++) matrix[i] <= '0;
      end else if (!is_ignored(code)) begin
        if (state == IDLE && code == B_EXT)
          state <= EXT;
        else if ((state == IDLE || state == EXT) && code == B_BRK)
          state <= ext ? EXT_BRK : BRK;
        else begin
          state <= IDLE;
          // typematic caps makes must not re-toggle, so toggling is gated by caps_held
          if (vk.hit)
            case (vk.kind)
              K_MATRIX: matrix[vk.row][vk.col] <= !brk;
              K_SS:     ss <= !brk;
              K_US:     us <= !brk;
              K_CAPS: begin
                caps_held <= !brk;
                if (!brk && !caps_held) key_caps <= !key_caps;
              end
            endcase
        end
      end
    end else if (state != IDLE) begin
      cnt <= tmo ? '0 : cnt + 20'd1;
      if (tmo) state <= IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cols_n  <= '1;
      mod_n   <= '1;
      any_key <= 1'b0;
    end else begin
      cols_n  <= ~sel_or;
      mod_n   <= {~ss, ~us, ~key_caps};
      any_key <= ss | us | caps_held | (|all_or);
    end
  end
endmodule
